decode_stage: RTL

- Decode stage of the in-order RISC-V pipeline, sitting directly upstream of register_file.
- Accepts instructions from fetch and decodes fields and immediates.
- Drives register_file read ports combinationally and registers operands plus decoded fields into a pipeline register for execute.
- Holds a per-register pending-write scoreboard and stalls on RAW hazards; there is no bypass.

---
 rtl/decode_stage_pkg.sv | 66 ++++++
 rtl/decode_stage_if.sv | 55 +++++
 rtl/decode_stage_scoreboard.sv | 60 ++++++
 rtl/decode_stage.sv | 124 ++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared types, sizes and the immediate generator for the decode stage.
// Everything that fetch, decode and execute must agree on lives here.
package decode_stage_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int REGISTER_DEPTH = 32;
    localparam int MAX_PENDING    = 3;
    localparam int AW             = $clog2(REGISTER_DEPTH);
    localparam int PW             = $clog2(MAX_PENDING + 1);

    typedef logic [REGISTER_WIDTH-1:0] word_t;
    typedef logic [AW-1:0]             reg_t;

    typedef enum logic [6:0] {
        OP     = 7'h33,
        OP_IMM = 7'h13,
        LOAD   = 7'h03,
        STORE  = 7'h23,
        BRANCH = 7'h63,
        JAL    = 7'h6F,
        JALR   = 7'h67,
        LUI    = 7'h37,
        AUIPC  = 7'h17,
        SYSTEM = 7'h73
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_format_t;

    // opcode kept raw so unknown encodings reach execute untouched
    typedef struct packed {
        logic [31:0] pc;
        word_t       rs1_data;
        word_t       rs2_data;
        word_t       imm;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        reg_t        rd;
        logic        writes_rd;
    } decoded_instr_t;

    function automatic word_t imm_gen(input logic [31:7] inst,
                                      input imm_format_t fmt);
        logic signed [31:0] t;
        t = '0;
        case (fmt)
            IMM_I: t = {{20{inst[31]}}, inst[31:20]};
            IMM_S: t = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: t = {{19{inst[31]}}, inst[31], inst[7],
                        inst[30:25], inst[11:8], 1'b0};
            IMM_U: t = {inst[31:12], 12'b0};
            IMM_J: t = {{11{inst[31]}}, inst[31], inst[19:12],
                        inst[20], inst[30:21], 1'b0};
            default: t = '0;
        endcase
        return REGISTER_WIDTH'(t);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus bundles around the decode stage: fetch input, register_file
// read port and the decoded output towards execute.
interface decode_in_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;

    modport master (output in_valid, in_instruction, in_pc,
                    input  in_ready);
    modport slave  (input  in_valid, in_instruction, in_pc,
                    output in_ready);
endinterface

interface decode_rf_if;
    import decode_stage_pkg::*;
    logic  rf_read_enable;
    reg_t  rf_read_address_1;
    reg_t  rf_read_address_2;
    word_t rf_read_data_1;
    word_t rf_read_data_2;

    modport master (output rf_read_enable, rf_read_address_1,
                           rf_read_address_2,
                    input  rf_read_data_1, rf_read_data_2);
    modport slave  (input  rf_read_enable, rf_read_address_1,
                           rf_read_address_2,
                    output rf_read_data_1, rf_read_data_2);
endinterface

interface decode_out_if;
    import decode_stage_pkg::*;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    word_t       out_rs1_data;
    word_t       out_rs2_data;
    word_t       out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    reg_t        out_rd;
    logic        out_writes_rd;

    modport master (output out_valid, out_pc, out_rs1_data,
                           out_rs2_data, out_imm, out_opcode,
                           out_funct3, out_funct7, out_rd,
                           out_writes_rd,
                    input  out_ready);
    modport slave  (input  out_valid, out_pc, out_rs1_data,
                           out_rs2_data, out_imm, out_opcode,
                           out_funct3, out_funct7, out_rd,
                           out_writes_rd,
                    output out_ready);
endinterface

// File: rtl/decode_stage_scoreboard.sv
// Per-register count of in-flight writes, used for RAW stall and
// for capping the number of outstanding writers to one register.
module decode_stage_scoreboard
    import decode_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  reg_t inc_addr_i,
    input  logic wb_dec_i,
    input  reg_t wb_addr_i,
    input  logic fl_dec_i,
    input  reg_t fl_addr_i,
    input  reg_t rs1_addr_i,
    input  reg_t rs2_addr_i,
    input  reg_t rd_addr_i,
    output logic rs1_busy_o,
    output logic rs2_busy_o,
    output logic rd_full_o
);

    logic [PW-1:0] pend_q [REGISTER_DEPTH];
    logic [PW-1:0] pend_d [REGISTER_DEPTH];
    logic [PW:0]   dn;
    logic [PW:0]   up;

    // decrements are clamped to the current count so stale retires
    // (after reset or to x0) can never underflow
    always_comb begin
        dn = '0;
        up = '0;
        for (int i = 0; i < REGISTER_DEPTH; i++) begin
            dn = '0;
            if (wb_dec_i && wb_addr_i == AW'(i))
                dn = dn + (PW+1)'(1);
            if (fl_dec_i && fl_addr_i == AW'(i))
                dn = dn + (PW+1)'(1);
            if (dn > {1'b0, pend_q[i]})
                dn = {1'b0, pend_q[i]};
            up = {1'b0, pend_q[i]} - dn;
            if (inc_i && inc_addr_i == AW'(i))
                up = up + (PW+1)'(1);
            pend_d[i] = (i == 0) ? '0 : PW'(up);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGISTER_DEPTH; i++)
                pend_q[i] <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign rs1_busy_o = pend_q[rs1_addr_i] != '0;
    assign rs2_busy_o = pend_q[rs2_addr_i] != '0;
    assign rd_full_o  = pend_q[rd_addr_i] == PW'(MAX_PENDING);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field/immediate decode, operand read, RAW stall on
// pending writes (no bypass) and one output register towards execute.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    decode_in_if.slave   fetch,
    decode_rf_if.master  rf,
    decode_out_if.master exec,
    input  logic         wb_valid,
    input  reg_t         wb_address,
    input  logic         flush
);

    logic [6:0]  opc;
    reg_t        rs1, rs2, rd;
    logic        uses_rs1, uses_rs2, wr_any, writes_rd;
    imm_format_t fmt;

    assign opc = fetch.in_instruction[6:0];
    assign rd  = fetch.in_instruction[11:7];
    assign rs1 = fetch.in_instruction[19:15];
    assign rs2 = fetch.in_instruction[24:20];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        wr_any   = 1'b0;
        fmt      = IMM_NONE;
        case (opc)
            OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; wr_any = 1'b1; end
            OP_IMM: begin uses_rs1 = 1'b1; wr_any = 1'b1; fmt = IMM_I; end
            LOAD:   begin uses_rs1 = 1'b1; wr_any = 1'b1; fmt = IMM_I; end
            STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; fmt = IMM_S; end
            BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; fmt = IMM_B; end
            JAL:    begin wr_any = 1'b1; fmt = IMM_J; end
            JALR:   begin uses_rs1 = 1'b1; wr_any = 1'b1; fmt = IMM_I; end
            LUI:    begin wr_any = 1'b1; fmt = IMM_U; end
            AUIPC:  begin wr_any = 1'b1; fmt = IMM_U; end
            SYSTEM: fmt = IMM_I;
            default: fmt = IMM_NONE;
        endcase
    end

    assign writes_rd = wr_any && (rd != '0);

    logic rs1_busy, rs2_busy, rd_full, hazard, issue, fl_dec;
    decoded_instr_t out_q, out_d;
    logic out_valid_q, out_valid_d;

    assign fl_dec = flush && out_valid_q && out_q.writes_rd;

    decode_stage_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (issue && writes_rd),
        .inc_addr_i (rd),
        .wb_dec_i   (wb_valid),
        .wb_addr_i  (wb_address),
        .fl_dec_i   (fl_dec),
        .fl_addr_i  (out_q.rd),
        .rs1_addr_i (rs1),
        .rs2_addr_i (rs2),
        .rd_addr_i  (rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_full_o  (rd_full)
    );

    // a retire in this cycle still stalls: the rf write lands next edge
    assign hazard = (uses_rs1 && rs1_busy) || (uses_rs2 && rs2_busy)
                 || (writes_rd && rd_full);
    assign fetch.in_ready = !flush && !hazard
                         && (!out_valid_q || exec.out_ready);
    assign issue = fetch.in_valid && fetch.in_ready;

    assign rf.rf_read_enable    = fetch.in_valid;
    assign rf.rf_read_address_1 = rs1;
    assign rf.rf_read_address_2 = rs2;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d     = 1'b1;
            out_d.pc        = fetch.in_pc;
            out_d.rs1_data  = rf.rf_read_data_1;
            out_d.rs2_data  = rf.rf_read_data_2;
            out_d.imm       = imm_gen(fetch.in_instruction[31:7], fmt);
            out_d.opcode    = opc;
            out_d.funct3    = fetch.in_instruction[14:12];
            out_d.funct7    = fetch.in_instruction[31:25];
            out_d.rd        = rd;
            out_d.writes_rd = writes_rd;
        end else if (exec.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign exec.out_valid     = out_valid_q;
    assign exec.out_pc        = out_q.pc;
    assign exec.out_rs1_data  = out_q.rs1_data;
    assign exec.out_rs2_data  = out_q.rs2_data;
    assign exec.out_imm       = out_q.imm;
    assign exec.out_opcode    = out_q.opcode;
    assign exec.out_funct3    = out_q.funct3;
    assign exec.out_funct7    = out_q.funct7;
    assign exec.out_rd        = out_q.rd;
    assign exec.out_writes_rd = out_q.writes_rd;

endmodule
